// File: rtl/wind_decoder.sv
// Receive-side decoder for the hazard_lights frame stream: classifies frame-to-frame
// transitions and reports a locked wind direction once enough consecutive ones agree.
module wind_decoder #(
    parameter int LOCK_COUNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] lights,
    output logic [1:0] wind,
    output logic       locked,
    output logic       err
);

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam logic [3:0] LC      = 4'(LOCK_COUNT);
    localparam logic [1:0] UNKNOWN = 2'b11;

    state_t     r_state, w_state_n;
    logic [2:0] r_prev,  w_prev_n;
    logic [1:0] r_last,  w_last_n;
    logic [3:0] r_run,   w_run_n;
    logic [1:0] r_wind,  w_wind_n;
    logic       r_err,   w_err_n;

    logic [2:0] w_cls;
    logic [3:0] w_run_valid;

    function automatic logic is_legal(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b101);
    endfunction

    // Returns {valid, class}; class 00 calm, 01 right-to-left, 10 left-to-right.
    function automatic logic [2:0] classify(input logic [2:0] p, input logic [2:0] c);
        case ({p, c})
            6'b101_010, 6'b010_101:             return 3'b1_00;
            6'b001_010, 6'b010_100, 6'b100_001: return 3'b1_01;
            6'b100_010, 6'b010_001, 6'b001_100: return 3'b1_10;
            default:                            return 3'b0_00;
        endcase
    endfunction

    assign w_cls = classify(r_prev, lights);

    // run only continues when the class repeats on a live run; it saturates at LOCK_COUNT
    assign w_run_valid = (w_cls[1:0] == r_last && r_run != 4'd0)
                       ? ((r_run >= LC) ? LC : r_run + 4'd1)
                       : 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
            r_prev  <= 3'b000;
            r_last  <= 2'b00;
            r_run   <= 4'd0;
            r_wind  <= UNKNOWN;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_prev  <= w_prev_n;
            r_last  <= w_last_n;
            r_run   <= w_run_n;
            r_wind  <= w_wind_n;
            r_err   <= w_err_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_prev_n  = r_prev;
        w_last_n  = r_last;
        w_run_n   = r_run;
        w_wind_n  = r_wind;
        w_err_n   = 1'b0;
        if (en) begin
            if (!is_legal(lights)) begin
                w_err_n   = 1'b1;
                w_run_n   = 4'd0;
                w_wind_n  = UNKNOWN;
                w_state_n = SEED;
            end else if (r_state == SEED) begin
                w_prev_n  = lights;
                w_state_n = TRACK;
            end else if (!w_cls[2]) begin
                w_err_n   = 1'b1;
                w_run_n   = 4'd0;
                w_wind_n  = UNKNOWN;
                w_prev_n  = lights;
                w_state_n = TRACK;
            end else begin
                w_run_n  = w_run_valid;
                w_last_n = w_cls[1:0];
                w_prev_n = lights;
                if (w_run_valid >= LC) begin
                    w_wind_n  = w_cls[1:0];
                    w_state_n = LOCK;
                end else begin
                    w_wind_n  = UNKNOWN;
                    w_state_n = TRACK;
                end
            end
        end
    end

    assign wind   = r_wind;
    assign locked = (r_state == LOCK);
    assign err    = r_err;

endmodule

// File: tb/tb_wind_decoder.sv
// Directed bench for wind_decoder (LOCK_COUNT=2); each check compares {wind, locked, err}.
module tb_wind_decoder;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] lights;
    logic [1:0] wind;
    logic       locked;
    logic       err;

    int total;
    int bad;

    wind_decoder #(.LOCK_COUNT(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .lights (lights),
        .wind   (wind),
        .locked (locked),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got wind/locked/err=%b required %b", tag, got, exp);
        end
    endtask

    task automatic frame(input string tag, input logic [2:0] f, input logic [3:0] exp);
        @(negedge clk);
        reset  = 1'b0;
        en     = 1'b1;
        lights = f;
        @(posedge clk);
        #1;
        check(tag, {wind, locked, err}, exp);
    endtask

    task automatic pulse_reset(input string tag, input logic [2:0] f, input logic e);
        @(negedge clk);
        reset  = 1'b1;
        en     = e;
        lights = f;
        @(posedge clk);
        #1;
        check(tag, {wind, locked, err}, 4'b1100);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
    endtask

    initial begin
        logic [2:0] junk [5];
        junk[0] = 3'b111; junk[1] = 3'b000; junk[2] = 3'b011;
        junk[3] = 3'b110; junk[4] = 3'b111;
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        en     = 1'b0;
        lights = 3'b000;

        pulse_reset("reset_state", 3'b000, 1'b0);

        // calm lock, then illegal frame and relock
        frame("calm_f1", 3'b101, 4'b1100);
        frame("calm_f2", 3'b010, 4'b1100);
        frame("calm_f3", 3'b101, 4'b0010);
        frame("illegal_111", 3'b111, 4'b1101);
        frame("reseed_101", 3'b101, 4'b1100);
        frame("reseed_010", 3'b010, 4'b1100);
        frame("relock_101", 3'b101, 4'b0010);

        // right-to-left lock and hold
        pulse_reset("reset_r2l", 3'b000, 1'b0);
        frame("r2l_f1", 3'b001, 4'b1100);
        frame("r2l_f2", 3'b010, 4'b1100);
        frame("r2l_f3", 3'b100, 4'b0110);
        frame("r2l_f4", 3'b001, 4'b0110);

        // left-to-right lock, then direction change
        pulse_reset("reset_l2r", 3'b000, 1'b0);
        frame("l2r_f1", 3'b100, 4'b1100);
        frame("l2r_f2", 3'b010, 4'b1100);
        frame("l2r_f3", 3'b001, 4'b1010);
        frame("chg_drop", 3'b010, 4'b1100);
        frame("chg_relock", 3'b100, 4'b0110);

        // reset mid-lock wins over en with an illegal frame present
        pulse_reset("reset_midlock", 3'b111, 1'b1);
        frame("post_rst_f1", 3'b001, 4'b1100);
        frame("post_rst_f2", 3'b010, 4'b1100);
        frame("post_rst_f3", 3'b100, 4'b0110);

        // repeated frame, then en gating with illegal lights
        pulse_reset("reset_gate", 3'b000, 1'b0);
        frame("rep_seed", 3'b101, 4'b1100);
        frame("rep_track", 3'b010, 4'b1100);
        frame("rep_err", 3'b010, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en     = 1'b0;
            lights = junk[i];
            @(posedge clk);
            #1;
            check($sformatf("gate_idle%0d", i), {wind, locked, err}, 4'b1100);
        end
        frame("gate_resume", 3'b101, 4'b1100);
        frame("gate_lock", 3'b010, 4'b0010);

        // back-to-back errors with en held high, then recovery
        frame("b2b_repeat", 3'b010, 4'b1101);
        frame("b2b_illegal", 3'b000, 4'b1101);
        frame("b2b_seed", 3'b101, 4'b1100);

        @(negedge clk);
        en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wind_decoder.md
# wind_decoder

Receive-side companion to `hazard_lights`. Watches the 3-bit hazard-light frame stream and recovers which wind setting produced it: calm, right-to-left or left-to-right. Classifies each frame-to-frame transition and asserts a locked wind code once enough consecutive transitions agree. Flags illegal frames and illegal transitions. Sits on the DE1_SoC board beside `hazard_lights`, sharing its clock domain.

## Interface

Parameters:
- `LOCK_COUNT`, default 2: number of consecutive same-class valid transitions required before `locked` asserts. Legal range is 1 to 15.

Ports:
- `clk`, input, 1 bit: the single clock. All state changes on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `en`, input, 1 bit: frame strobe. `lights` is sampled only on edges where `en`=1.
- `lights`, input, 3 bits: hazard-light frame. Bit 2 is the leftmost LED.
- `wind`, output, 2 bits: recovered wind code.
  - 00 = calm
  - 01 = right-to-left
  - 10 = left-to-right
  - 11 = unknown
- `locked`, output, 1 bit: 1 while `wind` holds a confirmed direction.
- `err`, output, 1 bit: one-cycle pulse on an illegal frame or illegal transition.

## Operation

Legal frames are 001, 010, 100 and 101. Frames 000, 011, 110 and 111 are illegal.

Transition classes, keyed on (previous frame → current frame):
- calm: 101→010 and 010→101.
- right-to-left: 001→010, 010→100, 100→001.
- left-to-right: 100→010, 010→001, 001→100.
- Every other legal→legal pair is invalid, including a repeated frame.

Internal state:
- `prev` (3 bits) and `prev_valid`.
- `last_class` (2 bits).
- `run`, a saturating counter that stops at `LOCK_COUNT`.

The block has three states:
- SEED: `prev_valid`=0.
- TRACK: `prev_valid`=1 and `locked`=0.
- LOCK: `locked`=1.

On each edge with `en`=1, apply the first matching rule:
1. Illegal frame:
   - `err` pulses; `prev_valid`←0, `run`←0.
   - `locked`←0, `wind`←11. Next state is SEED.
2. SEED:
   - `prev`←frame, `prev_valid`←1. No other change.
3. Invalid transition:
   - `err` pulses; `run`←0, `locked`←0, `wind`←11.
   - `prev`←frame, so the current frame seeds the next transition. Next state is TRACK.
4. Valid transition of class C:
   - If C equals `last_class` and `run`>0, then `run`←min(`run`+1, `LOCK_COUNT`). Otherwise `run`←1.
   - `last_class`←C, `prev`←frame.
   - If the new `run` ≥ `LOCK_COUNT`: `locked`←1, `wind`←C.
   - Otherwise: `locked`←0, `wind`←11.
   - A class change while in LOCK therefore drops lock immediately. With `LOCK_COUNT`=1 it relocks to the new class on the same edge.

On edges with `en`=0:
- All state holds.
- `err`←0.
- `lights` is ignored.

## Timing

- Reset values: `wind`=11, `locked`=0, `err`=0, `prev`=000, `prev_valid`=0, `run`=0, `last_class`=00.
- `reset` takes priority over `en`.
- Reset asserted mid-lock returns the block to reset values on that edge. The first frame after reset only seeds.
- All outputs are registered. The response to a frame sampled on edge N is visible after edge N and holds until the next sampling edge.
- From a clean start, lock needs `LOCK_COUNT`+1 frames. With the default of 2, `locked` rises after the 3rd frame.
- `err` is high for exactly one cycle per offending frame, even when `en` stays high on the next edge.
- `en` may be high every cycle (simulation) or a one-cycle strobe per slow-clock period (board). Behaviour is per sampled frame and does not depend on cycle spacing.

## Test plan

All scenarios use `LOCK_COUNT`=2 and `en`=1 unless stated.

1. Calm lock: reset, then frames 101, 010, 101.
   - After frames 1 and 2: `wind`=11, `locked`=0.
   - After frame 3: `wind`=00, `locked`=1.
2. Right-to-left lock: frames 001, 010, 100, 001.
   - After the 3rd frame: `wind`=01, `locked`=1.
   - After the 4th frame: still `wind`=01, `locked`=1.
3. Direction change: frames 100, 010, 001 lock `wind`=10.
   - Next frame 010 (a right-to-left transition): `locked`=0, `wind`=11, `err`=0.
   - Next frame 100: `wind`=01, `locked`=1.
4. Illegal frame: from calm lock, frame 111.
   - `err`=1 for one cycle, `locked`=0, `wind`=11.
   - Then 101 seeds, 010 gives `run`=1, and 101 relocks with `wind`=00.
5. Repeat and gating: from TRACK, frames 010, 010.
   - `err` pulses and `wind`=11.
   - Then hold `en`=0 for 5 cycles while `lights` toggles through illegal values: no output change and `err` stays 0.
6. Reset mid-lock: while locked with `wind`=01, assert `reset` for 1 cycle.
   - Outputs return to 11/0/0.
   - Frames 001, 010 do not lock; a following 100 locks with `wind`=01.
